// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_disp_pkg
// Description : Shared constants for the hex scan display: active-high
//               seven-segment table (bit 0 = a ... bit 6 = g), the all-off
//               active-low pattern and the digit-count limit.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_disp_pkg;

  // Active-high segment patterns for nibble values 0..F
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Active-low pattern with every segment dark
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Largest supported digit bank
  localparam int MAX_DIGITS = 8;

endpackage : hex_disp_pkg
`default_nettype wire

// File: rtl/hex_seg_lut.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_lut
// Description : Combinational nibble to active-low seven-segment decoder
//               driven from the shared package table.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table holds lit segments as ones; pins want them as zeros
  assign seg_n = ~SEG_TABLE[nibble];

endmodule : hex_seg_lut
`default_nettype wire

// File: rtl/hex_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_display
// Description : Time-multiplexed driver for NUM_DIGITS common-anode
//               seven-segment digits. A shadow buffer collects loads and is
//               promoted to the active buffer only at frame boundaries so a
//               frame never mixes two values. The first cycle of every digit
//               slot is a dark guard cycle to suppress ghosting.
//               Optional feature macro: HEX_SCAN_LZB_EN (leading-zero
//               blanking of digits 1..NUM_DIGITS-1).
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done
);

  localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_DIGITS - 1);

  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic [6:0]              w_lut_seg_n;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic                    w_dig_blank;
  logic [NUM_DIGITS-1:0]   w_dig_onehot;

  assign w_boundary   = (r_cnt == c_cnt_max) && (r_idx == c_idx_max);
  assign w_nib        = r_act_value[{r_idx, 2'b00} +: 4];
  assign w_dig_blank  = w_blank_mask[r_idx];
  assign w_dig_onehot = NUM_DIGITS'(1) << r_idx;

  hex_seg_lut u_seg_lut (
    .nibble (w_nib),
    .seg_n  (w_lut_seg_n)
  );

`ifdef HEX_SCAN_LZB_EN
  logic                  w_lz_run;
  logic [NUM_DIGITS-1:0] w_lzb;

  // Walk down from the top nibble; a digit is a leading zero while every
  // nibble from it upward is zero. Digit 0 always shows.
  always_comb begin
    w_lzb    = '0;
    w_lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_lz_run = w_lz_run & (r_act_value[4*k +: 4] == 4'h0);
      w_lzb[k] = w_lz_run;
    end
    w_blank_mask = r_act_blank | w_lzb;
  end
`else
  // Only the captured mask darkens digits
  always_comb begin
    w_blank_mask = r_act_blank;
  end
`endif

  // Prescaler and digit index: one slot per SCAN_DIV cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == c_cnt_max) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: loads go to shadow, promoted to active at frame end.
  // A load on the boundary cycle itself bypasses straight to active.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sh_value  <= '0;
      r_sh_blank  <= '0;
      r_pending   <= 1'b0;
      r_act_value <= '0;
      r_act_blank <= '0;
    end else begin
      if (load) begin
        r_sh_value <= value;
        r_sh_blank <= blank;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (load) begin
          r_act_value <= value;
          r_act_blank <= blank;
        end else if (r_pending) begin
          r_act_value <= r_sh_value;
          r_act_blank <= r_sh_blank;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered pin drivers, one cycle behind the scan state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_n      <= SEG_OFF;
      dig_n      <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= w_dig_blank ? SEG_OFF : w_lut_seg_n;
      dig_n      <= (r_cnt == '0) ? '1 : ~w_dig_onehot;
      frame_done <= w_boundary;
    end
  end

endmodule : hex_scan_display
`default_nettype wire

// File: tb/tb_hex_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_display
// Description : Self-checking bench for hex_scan_display (4 digits, 4-cycle
//               slots). A behavioural model derives the expected pins from
//               the elapsed cycle count since reset release and the load
//               history; scenario tasks also check fixed segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;

  logic            clk    = 1'b0;
  logic            resetn = 1'b0;
  logic            load   = 1'b0;
  logic [4*ND-1:0] value  = '0;
  logic [ND-1:0]   blank  = '0;
  logic [6:0]      seg_n;
  logic [ND-1:0]   dig_n;
  logic            frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Active-high reference patterns, 0..F
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  hex_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .value      (value),
    .blank      (blank),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         t       = 0;
  int         m_sh_v  = 0;
  int         m_sh_b  = 0;
  bit         m_pend  = 0;
  int         m_act_v = 0;
  int         m_act_b = 0;
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_dig = 4'hF;
  logic       exp_fd  = 1'b0;

  always @(posedge clk or negedge resetn) begin
    int  slot, phase, nib;
    bit  bnd, blk;
    if (!resetn) begin
      t = 0; m_sh_v = 0; m_sh_b = 0; m_pend = 0; m_act_v = 0; m_act_b = 0;
      exp_seg = 7'h7F; exp_dig = 4'hF; exp_fd = 1'b0;
    end else begin
      phase = t % SD;
      slot  = (t / SD) % ND;
      bnd   = (phase == SD - 1) && (slot == ND - 1);
      nib   = (m_act_v >> (4 * slot)) & 15;
      blk   = ((m_act_b >> slot) & 1) != 0;
`ifdef HEX_SCAN_LZB_EN
      if (slot >= 1 && (m_act_v >> (4 * slot)) == 0) blk = 1;
`endif
      exp_seg = blk ? 7'h7F : ~tbl[nib];
      exp_dig = (phase == 0) ? 4'hF : ~(4'b0001 << slot);
      exp_fd  = bnd;
      if (load) begin
        m_sh_v = int'(value); m_sh_b = int'(blank); m_pend = 1;
      end
      if (bnd) begin
        if (m_pend) begin m_act_v = m_sh_v; m_act_b = m_sh_b; end
        m_pend = 0;
      end
      t++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0; load = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (seg_n !== 7'h7F || dig_n !== 4'hF || frame_done !== 1'b0)
        $display("FAIL reset: seg_n=%h dig_n=%h fd=%b, required 7f f 0", seg_n, dig_n, frame_done);
      else n_pass++;
    end
    resetn = 1'b1;
  endtask

  task automatic test_load_scan();
    bit got = 0;
    @(negedge clk); load = 1'b1; value = 16'h1234; blank = '0;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL load_scan_wait: frame_done not seen, required within 40 cycles");
    else n_pass++;
    for (int j = 0; j < 16; j++) begin
      int slot = j / 4;
      @(negedge clk);
      n_checks++;
      if (seg_n !== exp_seg || dig_n !== exp_dig || frame_done !== exp_fd)
        $display("FAIL load_scan_model: seg_n=%h dig_n=%h fd=%b, required %h %h %b", seg_n, dig_n, frame_done, exp_seg, exp_dig, exp_fd);
      else n_pass++;
      n_checks++;
      if (j % 4 == 0) begin
        if (dig_n !== 4'hF) $display("FAIL load_scan_guard: dig_n=%h, required f", dig_n);
        else n_pass++;
      end else if (slot == 0) begin
        if (dig_n !== 4'hE || seg_n !== 7'h19) $display("FAIL load_scan_d0: dig_n=%h seg_n=%h, required e 19", dig_n, seg_n);
        else n_pass++;
      end else if (slot == 3) begin
        if (dig_n !== 4'h7 || seg_n !== 7'h79) $display("FAIL load_scan_d3: dig_n=%h seg_n=%h, required 7 79", dig_n, seg_n);
        else n_pass++;
      end else begin
        if (dig_n !== ~(4'b0001 << slot)) $display("FAIL load_scan_dig: dig_n=%h, required %h", dig_n, ~(4'b0001 << slot));
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_frame_load();
    bit got = 0;
    for (int k = 0; k < 40 && dig_n !== 4'hD; k++) @(negedge clk);
    load = 1'b1; value = 16'hABCD; blank = '0;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      n_checks++;
      if (seg_n !== exp_seg || dig_n !== exp_dig || frame_done !== exp_fd)
        $display("FAIL mid_load_model: seg_n=%h dig_n=%h fd=%b, required %h %h %b", seg_n, dig_n, frame_done, exp_seg, exp_dig, exp_fd);
      else n_pass++;
      if (dig_n === 4'h7) begin
        n_checks++;
        if (seg_n !== 7'h79) $display("FAIL mid_load_old: seg_n=%h, required 79", seg_n);
        else n_pass++;
      end
      if (frame_done === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) $display("FAIL mid_load_wait: frame_done not seen, required within 40 cycles");
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dig_n !== 4'hE || seg_n !== 7'h21) $display("FAIL mid_load_new: dig_n=%h seg_n=%h, required e 21", dig_n, seg_n);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    @(negedge clk); load = 1'b1; value = 16'h1111;
    @(negedge clk); value = 16'h2222;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL b2b_wait: frame_done not seen, required within 40 cycles");
    else n_pass++;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j % 4 != 0) begin
        n_checks++;
        if (seg_n !== 7'h24) $display("FAIL b2b_seg: dig_n=%h seg_n=%h, required 24", dig_n, seg_n);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blank_mask();
    bit got = 0;
    @(negedge clk); load = 1'b1; value = 16'($urandom); blank = 4'b0010;
    @(negedge clk); load = 1'b0; blank = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1;
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      n_checks++;
      if (seg_n !== exp_seg || dig_n !== exp_dig || frame_done !== exp_fd)
        $display("FAIL blank_model: seg_n=%h dig_n=%h fd=%b, required %h %h %b", seg_n, dig_n, frame_done, exp_seg, exp_dig, exp_fd);
      else n_pass++;
      if (j / 4 == 1 && j % 4 != 0) begin
        n_checks++;
        if (dig_n !== 4'hD || seg_n !== 7'h7F) $display("FAIL blank_d1: dig_n=%h seg_n=%h, required d 7f", dig_n, seg_n);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lzb();
    bit got = 0;
    logic [6:0] want [4];
`ifdef HEX_SCAN_LZB_EN
    want = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
    want = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
    @(negedge clk); load = 1'b1; value = 16'h0050; blank = '0;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1;
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j % 4 != 0) begin
        n_checks++;
        if (seg_n !== want[j / 4]) $display("FAIL lzb_d%0d: seg_n=%h, required %h", j / 4, seg_n, want[j / 4]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_checks++;
      if (seg_n !== exp_seg || dig_n !== exp_dig || frame_done !== exp_fd)
        $display("FAIL random_model: cyc=%0d seg_n=%h dig_n=%h fd=%b, required %h %h %b", c, seg_n, dig_n, frame_done, exp_seg, exp_dig, exp_fd);
      else n_pass++;
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      blank = 4'($urandom);
    end
    load = 1'b0; blank = '0;
  endtask

  task automatic test_reset_mid_frame();
    bit got = 0;
    for (int k = 0; k < 40 && dig_n !== 4'hB; k++) @(negedge clk);
    load = 1'b1; value = 16'h9999;
    @(negedge clk); load = 1'b0; resetn = 1'b0;
    #1;
    n_checks++;
    if (seg_n !== 7'h7F || dig_n !== 4'hF || frame_done !== 1'b0)
      $display("FAIL midreset_now: seg_n=%h dig_n=%h fd=%b, required 7f f 0", seg_n, dig_n, frame_done);
    else n_pass++;
    @(negedge clk); resetn = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg_n !== exp_seg || dig_n !== exp_dig || frame_done !== exp_fd)
        $display("FAIL midreset_model: seg_n=%h dig_n=%h fd=%b, required %h %h %b", seg_n, dig_n, frame_done, exp_seg, exp_dig, exp_fd);
      else n_pass++;
      if (dig_n === 4'hE) begin
        n_checks++;
        if (seg_n !== 7'h40) $display("FAIL midreset_zero: seg_n=%h, required 40", seg_n);
        else n_pass++;
      end
      if (frame_done === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) $display("FAIL midreset_wait: frame_done not seen, required within 40 cycles");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_mid_frame_load();
    test_back_to_back();
    test_blank_mask();
    test_lzb();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hex_scan_display
`default_nettype wire
